axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit per transaction.
REQ-004 SHALL have port ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port ARESET  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write), cmd_addr in ADDR_WIDTH, cmd_wdata in DATA_WIDTH: local command handshake.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_WIDTH, rsp_resp out 2, rsp_timeout out 1: local response handshake.
REQ-008 SHALL have AXI-Lite master ports AWADDR/AWVALID out, AWREADY in; WDATA/WVALID out, WREADY in; BRESP[1:0]/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RVALID in, RREADY out.

Function
REQ-009 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; one transaction outstanding.
REQ-010 cmd_ready SHALL be 1 only in IDLE; acceptance = cmd_valid & cmd_ready; cmd_addr/cmd_wdata captured into internal registers on acceptance.
REQ-011 Write accept in cycle N SHALL drive AWVALID=1 and WVALID=1 with registered address/data from cycle N+1 (state WR_REQ).
REQ-012 AWVALID SHALL deassert the cycle after AWVALID&AWREADY sampled; WVALID likewise on WVALID&WREADY; independent, either order, same cycle permitted.
REQ-013 AWADDR/WDATA SHALL remain stable while respective VALID is high.
REQ-014 When both AW and W handshakes complete, FSM SHALL enter WR_RESP with BREADY=1; on BVALID&BREADY capture BRESP into rsp_resp, rsp_rdata=0, go DONE.
REQ-015 Read accept in cycle N SHALL drive ARVALID=1 from N+1 (RD_REQ); on ARVALID&ARREADY deassert ARVALID, enter RD_RESP with RREADY=1.
REQ-016 In RD_RESP, RVALID&RREADY SHALL capture RDATA into rsp_rdata, rsp_resp=2'b00 (no RRESP on slave side), go DONE.
REQ-017 DONE SHALL hold rsp_valid=1 and stable rsp_* until rsp_ready; then IDLE; earliest next cmd acceptance the cycle after.
REQ-018 BREADY/RREADY SHALL be 1 only in WR_RESP/RD_RESP respectively.
REQ-019 Watchdog SHALL count cycles in WR_REQ, WR_RESP, RD_REQ, RD_RESP, clear on IDLE; at count == TIMEOUT_CYCLES-1 force all AXI VALID/READY low, rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0, go DONE.
REQ-020 A handshake completing in the same cycle as timeout SHALL take precedence over the timeout.
REQ-021 cmd_* changes outside IDLE SHALL be ignored.

Reset
REQ-022 ARESET SHALL force IDLE, watchdog=0, and outputs: cmd_ready=0 during reset then 1 in IDLE, AWVALID=WVALID=ARVALID=BREADY=RREADY=0, AWADDR=ARADDR=WDATA=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0.
REQ-023 Reset mid-transaction SHALL abandon it with no response issued.

Structure
REQ-024 Package axi_lite_pkg SHALL hold response codes (OKAY 2'b00, SLVERR 2'b10, DECERR/timeout 2'b11) and the master state enum.
REQ-025 Watchdog SHALL be sub-module axi_lite_watchdog (clear, enable, expired output); all else in one module.

Verification (bench: master wired to axi_lite_slave, default register values)
REQ-026 Read 0x08 -> rsp_rdata=0x0000_0100, rsp_resp=00, rsp_timeout=0.
REQ-027 Write 0x0C=0x0000_0010 then read 0x0C -> BRESP 00, read 0x0000_0010.
REQ-028 Write 0x40=0x1234_5678 -> rsp_resp=2'b10; read 0x40 -> rsp_rdata=0xDEAD_BEEF.
REQ-029 AWREADY forced 0 on write -> rsp_valid after 256 cycles, rsp_resp=11, rsp_timeout=1, AWVALID low.
REQ-030 rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0 throughout.
REQ-031 ARESET asserted during WR_RESP -> all AXI outputs 0 next cycle, no rsp_valid, next read 0x00 returns 0x0000_0001.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite master: response codes and FSM states.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // A watchdog expiry is reported to the local side with the DECERR code.
  localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } master_state_e;

  // States in which a bus transaction is in flight and the watchdog runs.
  function automatic logic is_active(master_state_e s);
    return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Per-transaction cycle counter; flags expiry once TIMEOUT_CYCLES-1 is reached.
module axi_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // The count saturates at the limit so expiry stays asserted if a late
  // handshake keeps the transaction alive past the limit cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master driven by a local command/response handshake.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // local command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // local response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  // AXI-Lite write channels
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // AXI-Lite read channels
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY
);

  import axi_lite_pkg::*;

  master_state_e         r_state;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_timeout;

  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_open;
  logic w_w_open;
  logic w_progress;
  logic w_timeout;

  assign w_wd_clear  = (r_state == IDLE);
  assign w_wd_enable = is_active(r_state);

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (ACLK),
    .i_reset  (ARESET),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expired(w_wd_expired)
  );

  // Decode handshakes this cycle; any handshake counts as progress and beats the watchdog.
  always_comb begin
    w_aw_hs    = r_awvalid & AWREADY;
    w_w_hs     = r_wvalid & WREADY;
    w_aw_open  = r_awvalid & ~AWREADY;
    w_w_open   = r_wvalid & ~WREADY;
    w_progress = 1'b0;
    case (r_state)
      WR_REQ:  w_progress = w_aw_hs | w_w_hs;
      WR_RESP: w_progress = BVALID;
      RD_REQ:  w_progress = ARREADY;
      RD_RESP: w_progress = RVALID;
      default: w_progress = 1'b0;
    endcase
    w_timeout = w_wd_expired & w_wd_enable & ~w_progress;
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_awaddr      <= '0;
      r_awvalid     <= 1'b0;
      r_wdata       <= '0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_araddr      <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_bready      <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_TIMEOUT;
      r_rsp_timeout <= 1'b1;
      r_state       <= DONE;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (!w_aw_open && !w_w_open) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= BRESP;
            r_rsp_timeout <= 1'b0;
            r_state       <= DONE;
          end
        end
        RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (RVALID) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= RDATA;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_state       <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;
  assign AWADDR      = r_awaddr;
  assign AWVALID     = r_awvalid;
  assign WDATA       = r_wdata;
  assign WVALID      = r_wvalid;
  assign BREADY      = r_bready;
  assign ARADDR      = r_araddr;
  assign ARVALID     = r_arvalid;
  assign RREADY      = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural register slave plus a reference register model.
module tb_axi_lite_master;

  localparam int TMO = 256;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP;

  int checks = 0;
  int errors = 0;

  bit awBlock = 1'b0;
  bit bBlock  = 1'b0;

  // slave state
  logic [31:0] slaveMem [16];
  logic        awLat, wLat, arLat;
  logic [31:0] awAddrQ, wDataQ, arAddrQ;

  // reference model of the slave register file
  logic [31:0] refRegs [16];

  always #5 ACLK = ~ACLK;

  axi_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Slave register file starts from its documented defaults.
  initial begin
    for (int i = 0; i < 16; i++) slaveMem[i] = 32'h0;
    slaveMem[0] = 32'h0000_0001;
    slaveMem[2] = 32'h0000_0100;
  end

  function automatic logic [31:0] slaveRead(input logic [31:0] a);
    return (a < 32'h40) ? slaveMem[a[5:2]] : 32'hDEAD_BEEF;
  endfunction

  // Behavioural AXI-Lite slave with random ready/valid timing; commits writes when B is issued.
  always @(posedge ACLK) begin
    if (ARESET) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= 32'h0;
      awLat <= 1'b0; wLat <= 1'b0; arLat <= 1'b0;
      awAddrQ <= 32'h0; wDataQ <= 32'h0; arAddrQ <= 32'h0;
    end else begin
      if (AWVALID && AWREADY) begin
        awLat <= 1'b1; awAddrQ <= AWADDR; AWREADY <= 1'b0;
      end else if (!awLat && !awBlock) AWREADY <= ($urandom_range(0, 1) == 1);
      else AWREADY <= 1'b0;

      if (WVALID && WREADY) begin
        wLat <= 1'b1; wDataQ <= WDATA; WREADY <= 1'b0;
      end else if (!wLat) WREADY <= ($urandom_range(0, 1) == 1);
      else WREADY <= 1'b0;

      if (BVALID && BREADY) BVALID <= 1'b0;
      else if (awLat && wLat && !BVALID && !bBlock && ($urandom_range(0, 1) == 1)) begin
        if (awAddrQ < 32'h40) begin
          slaveMem[awAddrQ[5:2]] <= wDataQ;
          BRESP <= 2'b00;
        end else BRESP <= 2'b10;
        BVALID <= 1'b1; awLat <= 1'b0; wLat <= 1'b0;
      end

      if (ARVALID && ARREADY) begin
        arLat <= 1'b1; arAddrQ <= ARADDR; ARREADY <= 1'b0;
      end else if (!arLat) ARREADY <= ($urandom_range(0, 1) == 1);
      else ARREADY <= 1'b0;

      if (RVALID && RREADY) begin
        RVALID <= 1'b0; arLat <= 1'b0;
      end else if (arLat && !RVALID && ($urandom_range(0, 1) == 1)) begin
        RVALID <= 1'b1; RDATA <= slaveRead(arAddrQ);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: writes below 0x40 update a register (OKAY), above answer SLVERR; reads above 0x40 give DEADBEEF.
  task automatic modelTxn(input bit isW, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] expData, output logic [1:0] expResp);
    if (isW) begin
      expData = 32'h0;
      if (a < 32'h40) begin
        refRegs[a[5:2]] = d;
        expResp = 2'b00;
      end else expResp = 2'b10;
    end else begin
      expData = (a < 32'h40) ? refRegs[a[5:2]] : 32'hDEAD_BEEF;
      expResp = 2'b00;
    end
  endtask

  // Issue one command and wait (bounded) for rsp_valid; latency counts edges after the accept edge.
  task automatic applyStimulus(input bit isW, input logic [31:0] a, input logic [31:0] d,
                               output int latency);
    int n;
    n = 0;
    @(negedge ACLK);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("cmdReadyWait", {63'h0, cmd_ready}, 64'h1);
    cmd_valid = 1'b1; cmd_write = isW; cmd_addr = a; cmd_wdata = d;
    @(negedge ACLK);
    // garbage on the command bus while busy must be ignored
    cmd_write = ~isW; cmd_addr = $urandom; cmd_wdata = $urandom;
    latency = 0;
    while (rsp_valid !== 1'b1 && latency < 600) begin
      @(negedge ACLK);
      latency++;
    end
    cmd_valid = 1'b0;
    checkOutput("rspValidWait", {63'h0, rsp_valid}, 64'h1);
  endtask

  task automatic finishResponse();
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    checkOutput("rspValidDrop", {63'h0, rsp_valid}, 64'h0);
  endtask

  task automatic runChecked(input string tag, input bit isW, input logic [31:0] a,
                            input logic [31:0] d);
    logic [31:0] eData;
    logic [1:0]  eResp;
    int          lat;
    modelTxn(isW, a, d, eData, eResp);
    applyStimulus(isW, a, d, lat);
    checkOutput({tag, ".rdata"}, {32'h0, rsp_rdata}, {32'h0, eData});
    checkOutput({tag, ".resp"}, {62'h0, rsp_resp}, {62'h0, eResp});
    checkOutput({tag, ".tmo"}, {63'h0, rsp_timeout}, 64'h0);
    repeat ($urandom_range(0, 3)) @(negedge ACLK);
    finishResponse();
  endtask

  task automatic doReset();
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  initial begin
    int lat;
    int n;
    bit isW;
    logic [31:0] addr;

    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) refRegs[i] = 32'h0;
    refRegs[0] = 32'h0000_0001;
    refRegs[2] = 32'h0000_0100;

    // reset values
    repeat (3) @(negedge ACLK);
    checkOutput("rst.cmdReady", {63'h0, cmd_ready}, 64'h0);
    checkOutput("rst.axiValidReady", {59'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 64'h0);
    checkOutput("rst.addrData", {AWADDR, ARADDR} | {32'h0, WDATA}, 64'h0);
    checkOutput("rst.rsp", {rsp_rdata, 28'h0, rsp_valid, rsp_resp, rsp_timeout}, 64'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("idle.cmdReady", {63'h0, cmd_ready}, 64'h1);

    // directed register accesses
    runChecked("rd08", 1'b0, 32'h08, 32'h0);
    runChecked("wr0C", 1'b1, 32'h0C, 32'h0000_0010);
    runChecked("rd0C", 1'b0, 32'h0C, 32'h0);
    runChecked("wr40", 1'b1, 32'h40, 32'h1234_5678);
    runChecked("rd40", 1'b0, 32'h40, 32'h0);

    // response held back: outputs stable, no new command accepted
    applyStimulus(1'b0, 32'h08, 32'h0, lat);
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      checkOutput($sformatf("hold%0d.valid", k), {63'h0, rsp_valid}, 64'h1);
      checkOutput($sformatf("hold%0d.rdata", k), {32'h0, rsp_rdata}, 64'h100);
      checkOutput($sformatf("hold%0d.resp", k), {61'h0, rsp_resp, rsp_timeout}, 64'h0);
      checkOutput($sformatf("hold%0d.cmdReady", k), {63'h0, cmd_ready}, 64'h0);
    end
    finishResponse();

    // randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      isW  = ($urandom_range(0, 1) == 1);
      addr = 32'h4 + 32'(4 * $urandom_range(0, 16));
      runChecked($sformatf("rnd%0d", i), isW, addr, $urandom);
    end

    // write with AWREADY stuck low times out
    awBlock = 1'b1;
    applyStimulus(1'b1, 32'h10, 32'hCAFE_F00D, lat);
    checkOutput("tmo.latency", 64'(lat), 64'(TMO));
    checkOutput("tmo.resp", {62'h0, rsp_resp}, 64'h3);
    checkOutput("tmo.flag", {63'h0, rsp_timeout}, 64'h1);
    checkOutput("tmo.rdata", {32'h0, rsp_rdata}, 64'h0);
    checkOutput("tmo.axiOut", {59'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 64'h0);
    finishResponse();
    awBlock = 1'b0;
    doReset();

    // reset while waiting in the write-response phase
    bBlock = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hAAAA_5555;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (BREADY !== 1'b1 && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("wrResp.reached", {63'h0, BREADY}, 64'h1);
    ARESET = 1'b1;
    @(negedge ACLK);
    checkOutput("midRst.axiOut", {59'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 64'h0);
    checkOutput("midRst.rspValid", {63'h0, rsp_valid}, 64'h0);
    ARESET = 1'b0;
    bBlock = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      checkOutput($sformatf("postRst%0d.rspValid", k), {63'h0, rsp_valid}, 64'h0);
    end
    runChecked("rd00", 1'b0, 32'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
